cpu_sequencer: RTL and testbench

Synthesizable fetch/decode/execute controller for the 8-bit processor. It drives the instruction memory, the 8-entry register file and the ALU, and replaces the behavioural sequencing currently done in the top-level bench. It holds the program counter and a latched instruction, and sequences one instruction at a time through a fixed per-class state path.

---
 rtl/cpu_pkg.sv | 63 ++++++
 rtl/seq_decode.sv | 57 +++++
 rtl/cpu_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor sequencer: instruction class
// encodings, ALU op codes, flag register address and bit positions, FSM
// state encoding and the decoded-instruction record produced by seq_decode.
package cpu_pkg;

  localparam logic [3:0] CLS_ADD   = 4'h0;
  localparam logic [3:0] CLS_SUB   = 4'h1;
  localparam logic [3:0] CLS_AND   = 4'h2;
  localparam logic [3:0] CLS_OR    = 4'h3;
  localparam logic [3:0] CLS_XOR   = 4'h4;
  localparam logic [3:0] CLS_INV   = 4'h5;
  localparam logic [3:0] CLS_UNDEF = 4'h6;
  localparam logic [3:0] CLS_MOV   = 4'h7;
  localparam logic [3:0] CLS_LOAD  = 4'h8;
  localparam logic [3:0] CLS_JZ    = 4'h9;
  localparam logic [3:0] CLS_INC   = 4'hA;
  localparam logic [3:0] CLS_DEC   = 4'hB;
  localparam logic [3:0] CLS_HLT   = 4'hC;
  localparam logic [3:0] CLS_JC    = 4'hD;
  localparam logic [3:0] CLS_JNZ   = 4'hE;
  localparam logic [3:0] CLS_JMP   = 4'hF;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_INV = 3'd5
  } alu_op_e;

  // Default register-file address of the flags register {cy, zero, 6'b0}.
  localparam logic [2:0] SEQ_FLAG_ADDR = 3'd7;
  localparam int         FLG_CY        = 7;
  localparam int         FLG_Z         = 6;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_RD_A, S_RD_B,
    S_EXEC, S_WB, S_WB_FLG, S_BR, S_HALT
  } seq_state_e;

  typedef struct packed {
    logic       is_alu2;      // two-operand ALU op (ADD..XOR)
    logic       is_inv;
    logic       is_incdec;
    logic       is_mov;
    logic       is_load;
    logic       is_jmp;
    logic       is_jz;
    logic       is_jc;
    logic       is_jnz;
    logic       is_hlt;
    logic       is_undef;
    logic       is_jump;
    logic       writes_flags;
    alu_op_e    alu_op;
    logic [1:0] dst;
    logic [1:0] src_b;
    logic [1:0] rd_a_sel;     // register read in RD_A (srcA, or dst for INC/DEC/JNZ)
    logic [7:0] imm;
  } seq_dec_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder for cpu_sequencer.
// Ports:
//   ir  - latched 16-bit instruction word
//   dec - class one-hots, register fields, ALU op, flag-write and jump flags
module seq_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output seq_dec_t    dec
);

  logic [3:0] cls;
  logic       unused_ir;

  assign cls       = ir[15:12];
  assign unused_ir = ^{ir[11:10], ir[3:2]};

  always_comb begin
    // NOTE: every field gets a default first so no path leaves one unassigned (no latch).
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.dst    = ir[9:8];
    dec.src_b  = ir[1:0];
    dec.imm    = ir[7:0];

    case (cls)
      CLS_ADD, CLS_SUB, CLS_AND, CLS_OR, CLS_XOR: begin
        dec.is_alu2 = 1'b1;
        dec.alu_op  = alu_op_e'(cls[2:0]);
      end
      CLS_INV: begin
        dec.is_inv = 1'b1;
        dec.alu_op = ALU_INV;
      end
      CLS_INC:   dec.is_incdec = 1'b1;
      CLS_DEC: begin
        dec.is_incdec = 1'b1;
        dec.alu_op    = ALU_SUB;
      end
      CLS_MOV:   dec.is_mov   = 1'b1;
      CLS_LOAD:  dec.is_load  = 1'b1;
      CLS_JZ:    dec.is_jz    = 1'b1;
      CLS_JC:    dec.is_jc    = 1'b1;
      CLS_JNZ:   dec.is_jnz   = 1'b1;
      CLS_JMP:   dec.is_jmp   = 1'b1;
      CLS_HLT:   dec.is_hlt   = 1'b1;
      CLS_UNDEF: dec.is_undef = 1'b1;
      default:   dec.is_undef = 1'b1;
    endcase

    dec.is_jump      = dec.is_jmp | dec.is_jz | dec.is_jc | dec.is_jnz;
    dec.writes_flags = dec.is_alu2 | dec.is_inv | dec.is_incdec;
    // INC/DEC modify dst in place and JNZ tests dst, so those read dst.
    dec.rd_a_sel     = (dec.is_incdec | dec.is_jnz) ? ir[9:8] : ir[5:4];
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit processor. Holds the program
// counter and latched instruction and walks each instruction through a fixed
// per-class state path, driving instruction memory, register file and ALU.
// Optional feature macro: SEQ_UNDEF_TRAP_EN (class 0110 traps to HALT and
// sets the sticky illegal flag; otherwise it is a 2-cycle NOP and illegal = 0).
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   run                - start/continue execution (sampled in IDLE and at fetch entry)
//   pc, ir_en, ir_data - instruction memory address / enable / word
//   rf_addr, rf_rd, rf_wr, rf_wdata, rf_rdata - register file access
//   alu_op, alu_a, alu_b, alu_out, alu_cy, alu_zero - ALU interface
//   busy, halted, illegal - status
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int         PC_W      = 8,
  parameter logic [2:0] FLAG_ADDR = SEQ_FLAG_ADDR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic [PC_W-1:0] pc,
  output logic            ir_en,
  input  logic [15:0]     ir_data,
  output logic [2:0]      rf_addr,
  output logic            rf_rd,
  output logic            rf_wr,
  output logic [7:0]      rf_wdata,
  input  logic [7:0]      rf_rdata,
  output logic [2:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_b,
  input  logic [7:0]      alu_out,
  input  logic            alu_cy,
  input  logic            alu_zero,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  seq_state_e      state;
  logic [15:0]     ir_q;
  logic [7:0]      a_q;
  logic [7:0]      b_q;
  logic            cy_q;
  logic            zero_q;
  seq_dec_t        dec;
  logic            taken;
  logic [PC_W-1:0] fetch_pc;

  seq_decode u_decode (
    .ir  (ir_q),
    .dec (dec)
  );

  // Operands are the latches themselves; they are only meaningful in EXEC.
  assign alu_a = a_q;
  assign alu_b = b_q;

  assign taken = dec.is_jmp
               | (dec.is_jz  & a_q[FLG_Z])
               | (dec.is_jc  & a_q[FLG_CY])
               | (dec.is_jnz & (a_q != 8'h00));

  // Address of the next fetch whenever an instruction completes.
  assign fetch_pc = (state == S_BR && taken) ? PC_W'(dec.imm) : pc + PC_W'(1);

`ifdef SEQ_UNDEF_TRAP_EN
  logic illegal_q;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir_en    <= 1'b0;
      rf_addr  <= '0;
      rf_rd    <= 1'b0;
      rf_wr    <= 1'b0;
      rf_wdata <= '0;
      alu_op   <= ALU_ADD;
      busy     <= 1'b0;
      halted   <= 1'b0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SEQ_UNDEF_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      // NOTE: state and registered outputs use non-blocking assignment so every
      // read in this block sees the pre-edge value.
      // Strobes are single-cycle; only the transition into their state raises them.
      ir_en <= 1'b0;
      rf_rd <= 1'b0;
      rf_wr <= 1'b0;

      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            ir_en <= 1'b1;
            busy  <= 1'b1;
          end
        end

        S_FETCH: begin
          ir_q  <= ir_data;
          state <= S_DECODE;
        end

        S_DECODE: begin
          if (dec.is_load) begin
            state    <= S_WB;
            rf_wr    <= 1'b1;
            rf_addr  <= {1'b0, dec.dst};
            rf_wdata <= dec.imm;
          end else if (dec.is_jmp) begin
            state <= S_BR;
          end else if (dec.is_hlt) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else if (dec.is_undef) begin
`ifdef SEQ_UNDEF_TRAP_EN
            state     <= S_HALT;
            busy      <= 1'b0;
            halted    <= 1'b1;
            illegal_q <= 1'b1;
`else
            pc    <= fetch_pc;
            state <= run ? S_FETCH : S_IDLE;
            ir_en <= run;
            busy  <= run;
`endif
          end else begin
            state   <= S_RD_A;
            rf_rd   <= 1'b1;
            rf_addr <= (dec.is_jz | dec.is_jc) ? FLAG_ADDR : {1'b0, dec.rd_a_sel};
          end
        end

        S_RD_A: begin
          a_q <= rf_rdata;
          if (dec.is_mov) begin
            state    <= S_WB;
            rf_wr    <= 1'b1;
            rf_addr  <= {1'b0, dec.dst};
            rf_wdata <= rf_rdata;
          end else if (dec.is_jump) begin
            state <= S_BR;
          end else if (dec.is_inv | dec.is_incdec) begin
            state  <= S_EXEC;
            b_q    <= dec.is_inv ? 8'h00 : 8'h01;
            alu_op <= dec.alu_op;
          end else begin
            state   <= S_RD_B;
            rf_rd   <= 1'b1;
            rf_addr <= {1'b0, dec.src_b};
          end
        end

        S_RD_B: begin
          b_q    <= rf_rdata;
          alu_op <= dec.alu_op;
          state  <= S_EXEC;
        end

        S_EXEC: begin
          cy_q     <= alu_cy;
          zero_q   <= alu_zero;
          state    <= S_WB;
          rf_wr    <= 1'b1;
          rf_addr  <= {1'b0, dec.dst};
          rf_wdata <= alu_out;
        end

        S_WB: begin
          if (dec.writes_flags) begin
            state    <= S_WB_FLG;
            rf_wr    <= 1'b1;
            rf_addr  <= FLAG_ADDR;
            rf_wdata <= {cy_q, zero_q, 6'b0};
          end else begin
            pc    <= fetch_pc;
            state <= run ? S_FETCH : S_IDLE;
            ir_en <= run;
            busy  <= run;
          end
        end

        S_WB_FLG, S_BR: begin
          pc    <= fetch_pc;
          state <= run ? S_FETCH : S_IDLE;
          ir_en <= run;
          busy  <= run;
        end

        S_HALT: state <= S_HALT;

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: instruction memory, register file
// and ALU models, directed programs, and a write scoreboard whose monitor
// compares every register-file write against the expected queue.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [7:0]  pc;
  logic        ir_en;
  logic [15:0] ir_data;
  logic [2:0]  rf_addr;
  logic        rf_rd, rf_wr;
  logic [7:0]  rf_wdata, rf_rdata;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_cy, alu_zero;
  logic        busy, halted, illegal;

  logic [15:0] imem [256];
  logic [7:0]  regs [8];
  logic        rf_clear = 1'b0;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(8), .FLAG_ADDR(3'd7)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .pc       (pc),
    .ir_en    (ir_en),
    .ir_data  (ir_data),
    .rf_addr  (rf_addr),
    .rf_rd    (rf_rd),
    .rf_wr    (rf_wr),
    .rf_wdata (rf_wdata),
    .rf_rdata (rf_rdata),
    .alu_op   (alu_op),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_out  (alu_out),
    .alu_cy   (alu_cy),
    .alu_zero (alu_zero),
    .busy     (busy),
    .halted   (halted),
    .illegal  (illegal)
  );

  assign ir_data  = imem[pc];
  assign rf_rdata = regs[rf_addr];

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
    end else if (rf_wr) begin
      regs[rf_addr] <= rf_wdata;
    end
  end

  // Reference ALU: carry is the 9th bit of add, borrow for sub.
  always_comb begin
    alu_out = 8'h00;
    alu_cy  = 1'b0;
    case (alu_op)
      3'd0: {alu_cy, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: {alu_cy, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
      3'd2: alu_out = alu_a & alu_b;
      3'd3: alu_out = alu_a | alu_b;
      3'd4: alu_out = alu_a ^ alu_b;
      3'd5: alu_out = ~alu_a;
      default: alu_out = 8'h00;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every register-file write must match the queue head.
  always @(negedge clk) begin
    if (!rst && rf_wr) begin
      check("rd_wr_exclusive", 32'(rf_rd), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rf_addr, rf_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("rf_write", 32'({rf_addr, rf_wdata}), 32'({e.addr, e.data}));
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, 32'({pc, ir_en, rf_addr, rf_rd, rf_wr, rf_wdata, alu_op, busy, halted, illegal}), 32'd0);
    check({name, "_alu_ab"}, 32'({alu_a, alu_b}), 32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    run      = 1'b0;
    rf_clear = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    rf_clear = 1'b0;
    rst      = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 16'hC000;
  endtask

  task automatic wait_fetch(output logic [7:0] p, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ir_en && n < 64);
    check("fetch_seen", 32'(ir_en), 32'd1);
    p = pc;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic check_drain(input string name);
    repeat (2) @(posedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] p;
    int n;
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] p;
    int n;
    bit found;

    // Test 1: LOAD R0,5; LOAD R1,3; ADD R2,R0,R1; HLT
    do_reset();
    imem[0] = 16'h8005;
    imem[1] = 16'h8103;
    imem[2] = 16'h0201;
    imem[3] = 16'hC000;
    push_wr(3'd0, 8'h05);
    push_wr(3'd1, 8'h03);
    push_wr(3'd2, 8'h08);
    push_wr(3'd7, 8'h00);
    run = 1'b1;
    wait_fetch(p, n);
    check("t1_first_pc", 32'(p), 32'h0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_halt(n);
    check("t1_cycles", 32'(n), 32'd15);
    check("t1_pc", 32'(pc), 32'h3);
    check("t1_busy_halt", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_halt_sticky", 32'({halted, pc}), 32'h103);
    check("t1_r2", 32'(regs[2]), 32'h08);
    check_drain("t1_drain");

    // Test 2: LOAD R0,FF; INC R0; JZ 10 -> HLT at 0x10
    do_reset();
    imem[0]     = 16'h80FF;
    imem[1]     = 16'hA000;
    imem[2]     = 16'h9010;
    imem[8'h10] = 16'hC000;
    push_wr(3'd0, 8'hFF);
    push_wr(3'd0, 8'h00);
    push_wr(3'd7, 8'hC0);
    run = 1'b1;
    wait_halt(n);
    check("t2_pc", 32'(pc), 32'h10);
    check("t2_flags", 32'(regs[7]), 32'hC0);
    check_drain("t2_drain");

    // Test 3: LOAD R1,3; DEC R1; JNZ R1,1; HLT
    do_reset();
    imem[0] = 16'h8103;
    imem[1] = 16'hB100;
    imem[2] = 16'hE101;
    imem[3] = 16'hC000;
    push_wr(3'd1, 8'h03);
    push_wr(3'd1, 8'h02);
    push_wr(3'd7, 8'h00);
    push_wr(3'd1, 8'h01);
    push_wr(3'd7, 8'h00);
    push_wr(3'd1, 8'h00);
    push_wr(3'd7, 8'h40);
    run = 1'b1;
    wait_halt(n);
    check("t3_pc", 32'(pc), 32'h3);
    check("t3_r1", 32'(regs[1]), 32'h00);
    check_drain("t3_drain");

    // Test 4a: JMP at 0xFF targeting 0
    do_reset();
    imem[0]     = 16'hF0FF;
    imem[8'hFF] = 16'hF000;
    run = 1'b1;
    wait_fetch(p, n);
    wait_fetch(p, n);
    check("t4a_at_ff", 32'(p), 32'hFF);
    wait_fetch(p, n);
    check("t4a_wrap", 32'(p), 32'h00);
    check("t4a_jmp_cycles", 32'(n), 32'd3);

    // Test 4b: non-jump at 0xFF wraps to 0
    do_reset();
    imem[0]     = 16'hF0FF;
    imem[8'hFF] = 16'h835A;
    push_wr(3'd3, 8'h5A);
    run = 1'b1;
    wait_fetch(p, n);
    wait_fetch(p, n);
    check("t4b_at_ff", 32'(p), 32'hFF);
    wait_fetch(p, n);
    check("t4b_wrap", 32'(p), 32'h00);
    check("t4b_load_cycles", 32'(n), 32'd3);
    check("t4b_drain", 32'(exp_q.size()), 32'd0);

    // Test 5: undefined class 0110
    do_reset();
    imem[0] = 16'h6000;
    imem[1] = 16'hC000;
    run = 1'b1;
`ifdef SEQ_UNDEF_TRAP_EN
    wait_halt(n);
    check("t5_trap_pc", 32'(pc), 32'h0);
    check("t5_illegal", 32'(illegal), 32'd1);
`else
    wait_fetch(p, n);
    wait_fetch(p, n);
    check("t5_nop_pc", 32'(p), 32'h1);
    check("t5_nop_cycles", 32'(n), 32'd2);
    wait_halt(n);
    check("t5_illegal", 32'(illegal), 32'd0);
`endif

    // Test 6: reset asserted during the WB of ADD
    do_reset();
    imem[0] = 16'h8005;
    imem[1] = 16'h8103;
    imem[2] = 16'h0201;
    push_wr(3'd0, 8'h05);
    push_wr(3'd1, 8'h03);
    run   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk);
      #1;
      if (rf_wr && rf_addr == 3'd2) found = 1'b1;
    end
    check("t6_add_wb_seen", 32'(found), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_wr_drop", 32'(rf_wr), 32'd0);
    check_reset_outputs("t6_reset_outputs");
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_no_writes", 32'({regs[2], regs[7]}), 32'h0);
    check("t6_idle", 32'({busy, halted}), 32'd0);
    check("t6_drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
